// File: rtl/fifo_read_arbiter_pkg.sv
// Shared types and constants for the FIFO read-port arbiter.
// Holds the FSM state encoding, the default sizes and the consumer-ID width helper.
package fifo_read_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  // Width of a consumer index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Bundle of the read-port arbiter's request, FIFO and return signals.
// The arbiter uses the master modport; the consumers and FIFO use the slave modport.
interface fifo_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int BL_W    = 3
) ();
  import fifo_read_arbiter_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [BL_W-1:0]    burst_len;
  logic               empty;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_en;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [ID_W-1:0]    out_id;

  modport master (
    input  req, burst_len, empty, rd_data,
    output rd_en, gnt, busy, out_valid, out_data, out_id
  );

  modport slave (
    output req, burst_len, empty, rd_data,
    input  rd_en, gnt, busy, out_valid, out_data, out_id
  );

endinterface

// File: rtl/fifo_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after last_gnt, searching upward with wrap.
// Produces a one-hot grant and its index; both are zero when nothing is requested.
module rr_arbiter
  import fifo_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_gnt,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W-1:0] idx;

  // Walk from farthest to nearest so the nearest candidate overwrites the others.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(last_gnt) + i) % NUM_REQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares one FIFO read port between NUM_REQ consumers: round-robin grants, bursts of
// empty-gated pops, and a one-cycle return path that tags each word with its owner.
module fifo_read_arbiter
  import fifo_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int BL_W      = 3
) (
  input logic                r_clk,
  input logic                rst,
  fifo_read_arbiter_if.master bus
);

  localparam int ID_W = id_width(NUM_REQ);

  // Zero and oversize requests both mean a full-length burst.
  function automatic logic [BL_W-1:0] sat_burst(input logic [BL_W-1:0] bl);
    if (bl == '0 || int'(bl) > MAX_BURST) begin
      return BL_W'(MAX_BURST);
    end
    return bl;
  endfunction

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [ID_W-1:0]    last_gnt_q, last_gnt_d;
  logic [BL_W-1:0]    count_q, count_d;
  logic               vld_p1_q, vld_p1_d;
  logic [ID_W-1:0]    id_p1_q, id_p1_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               rd_en;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req      (bus.req),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  // Same condition the read pointer uses to advance, so a pop is never issued while empty.
  assign rd_en = (state_q == BURST) && !bus.empty && bus.req[gnt_idx_q] &&
                 (count_q != '0) && !rst;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    last_gnt_d = last_gnt_q;
    count_d    = count_q;
    vld_p1_d   = rd_en;
    id_p1_d    = gnt_idx_q;

    unique case (state_q)
      IDLE: begin
        if ((bus.req != '0) && !bus.empty) begin
          state_d    = BURST;
          gnt_d      = arb_gnt;
          gnt_idx_d  = arb_idx;
          last_gnt_d = arb_idx;
          count_d    = sat_burst(bus.burst_len);
        end
      end
      BURST: begin
        if (!bus.req[gnt_idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          count_d = '0;
        end else if (rd_en) begin
          count_d = count_q - BL_W'(1);
          if (count_q == BL_W'(1)) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_gnt_q <= ID_W'(NUM_REQ - 1);
      count_q    <= '0;
      vld_p1_q   <= 1'b0;
      id_p1_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      last_gnt_q <= last_gnt_d;
      count_q    <= count_d;
      vld_p1_q   <= vld_p1_d;
      id_p1_q    <= id_p1_d;
    end
  end

  // Return stage: memory data arrives one cycle after the pop and passes straight through.
  assign bus.rd_en     = rd_en;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q == BURST);
  assign bus.out_valid = vld_p1_q;
  assign bus.out_id    = id_p1_q;
  assign bus.out_data  = vld_p1_q ? bus.rd_data : '0;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: a queue-based FIFO plus an owner/remaining-words model
// checked every cycle, directed scenarios pinned with literal expectations, then random traffic.
module tb_fifo_read_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int BL_W      = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_read_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BL_W(BL_W)) bus ();

  fifo_read_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST),
    .BL_W      (BL_W)
  ) dut (
    .r_clk (clk),
    .rst   (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] fifo[$];
  bit                force_empty;

  int                m_owner;
  int                m_rem;
  int                m_last;
  bit                m_ovld;
  int                m_oid;
  logic [DATA_W-1:0] m_odata;

  int                pop_log[$];
  logic [DATA_W-1:0] data_log[$];
  int                id_log[$];
  int                stall_cnt;
  logic              s_rd_en, s_busy, s_ovld;
  logic [NUM_REQ-1:0] s_gnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    pop_log.delete();
    data_log.delete();
    id_log.delete();
    stall_cnt = 0;
  endtask

  task automatic tick();
    bit                 e_rd, e_busy, popped;
    logic [NUM_REQ-1:0] e_gnt;
    logic [DATA_W-1:0]  w;
    bus.empty = force_empty || (fifo.size() == 0);
    @(negedge clk);
    e_busy = (m_owner >= 0);
    e_gnt  = e_busy ? NUM_REQ'(1 << m_owner) : '0;
    e_rd   = e_busy && !bus.empty && bus.req[m_owner] && !rst;
    chk("gnt", bus.gnt, e_gnt);
    chk("busy", bus.busy, e_busy);
    chk("rd_en", bus.rd_en, e_rd);
    chk("out_valid", bus.out_valid, m_ovld);
    chk("out_data", bus.out_data, m_ovld ? m_odata : '0);
    if (m_ovld) chk("out_id", bus.out_id, m_oid);
    chk("gnt_onehot0", $onehot0(bus.gnt), 1);
    s_rd_en = bus.rd_en;
    s_busy  = bus.busy;
    s_ovld  = bus.out_valid;
    s_gnt   = bus.gnt;
    if (bus.rd_en) pop_log.push_back(oh_idx(bus.gnt));
    if (bus.out_valid) begin
      data_log.push_back(bus.out_data);
      id_log.push_back(int'(bus.out_id));
    end
    if (bus.busy && !bus.rd_en && bus.empty) stall_cnt++;
    @(posedge clk);
    popped = 0;
    w      = '0;
    if (rst) begin
      m_owner = -1;
      m_rem   = 0;
      m_last  = NUM_REQ - 1;
      m_ovld  = 0;
      m_oid   = 0;
    end else begin
      m_ovld = e_rd;
      if (e_rd) begin
        m_oid   = m_owner;
        w       = fifo.pop_front();
        m_odata = w;
        popped  = 1;
      end
      if (m_owner < 0) begin
        if (bus.req != '0 && !bus.empty) begin
          for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (m_last + k) % NUM_REQ;
            if (bus.req[c]) begin
              m_owner = c;
              m_last  = c;
              break;
            end
          end
          m_rem = (bus.burst_len == 0 || int'(bus.burst_len) > MAX_BURST) ?
                  MAX_BURST : int'(bus.burst_len);
        end
      end else if (!bus.req[m_owner]) begin
        m_owner = -1;
      end else if (e_rd) begin
        m_rem--;
        if (m_rem == 0) m_owner = -1;
      end
    end
    #1;
    bus.rd_data = popped ? w : DATA_W'($urandom);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.burst_len = '0;
    bus.rd_data   = '0;
    bus.empty     = 1'b1;
    force_empty   = 0;
    m_owner = -1; m_rem = 0; m_last = NUM_REQ - 1; m_ovld = 0; m_oid = 0; m_odata = '0;
    clear_logs();
    @(posedge clk);
    #1;
    tick();
    chk("rst_gnt", s_gnt, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_rd_en", s_rd_en, 0);
    chk("rst_out_valid", s_ovld, 0);
    chk("rst_out_id", bus.out_id, 0);
    rst = 1'b0;

    // Single requester, burst of 3 out of 5 buffered words.
    clear_logs();
    for (int i = 0; i < 5; i++) fifo.push_back(DATA_W'(8'hA0 + i));
    bus.req = 4'b0001; bus.burst_len = 3;
    repeat (4) tick();
    bus.req = '0;
    repeat (3) tick();
    chk("single_pops", pop_log.size(), 3);
    chk("single_words", data_log.size(), 3);
    if (data_log.size() == 3) begin
      chk("single_d0", data_log[0], 8'hA0);
      chk("single_d1", data_log[1], 8'hA1);
      chk("single_d2", data_log[2], 8'hA2);
      chk("single_id", id_log[2], 0);
    end
    fifo.delete();

    // Round robin over requesters 0,1,3 with single-word bursts.
    rst = 1'b1; tick(); rst = 1'b0;
    clear_logs();
    for (int i = 0; i < 20; i++) fifo.push_back(DATA_W'($urandom));
    bus.req = 4'b1011; bus.burst_len = 1;
    repeat (12) tick();
    bus.req = '0;
    repeat (2) tick();
    chk("rr_pops", pop_log.size(), 6);
    if (pop_log.size() == 6) begin
      chk("rr_0", pop_log[0], 0); chk("rr_1", pop_log[1], 1); chk("rr_2", pop_log[2], 3);
      chk("rr_3", pop_log[3], 0); chk("rr_4", pop_log[4], 1); chk("rr_5", pop_log[5], 3);
    end
    fifo.delete();

    // Empty stall: 2 words, 5 empty cycles, then 2 more words.
    clear_logs();
    bus.req = 4'b0001; bus.burst_len = 4;
    fifo.push_back(8'h11); fifo.push_back(8'h22);
    repeat (8) tick();
    fifo.push_back(8'h33); fifo.push_back(8'h44);
    repeat (2) tick();
    bus.req = '0;
    repeat (2) tick();
    chk("stall_pops", pop_log.size(), 4);
    chk("stall_cycles", stall_cnt, 5);
    chk("stall_words", data_log.size(), 4);
    if (data_log.size() == 4) chk("stall_d3", data_log[3], 8'h44);

    // Request withdrawal after the second pop of a 4-word burst.
    clear_logs();
    for (int i = 0; i < 6; i++) fifo.push_back(DATA_W'(8'hC0 + i));
    bus.req = 4'b0100; bus.burst_len = 4;
    repeat (3) tick();
    bus.req = '0;
    repeat (2) tick();
    chk("wd_pops", pop_log.size(), 2);
    chk("wd_words", data_log.size(), 2);
    if (id_log.size() == 2) begin
      chk("wd_id0", id_log[0], 2);
      chk("wd_id1", id_log[1], 2);
    end
    chk("wd_idle", s_busy, 0);
    fifo.delete();

    // burst_len 0 and 7 both give a full-length burst.
    for (int b = 0; b < 2; b++) begin
      clear_logs();
      for (int i = 0; i < 8; i++) fifo.push_back(DATA_W'($urandom));
      bus.req = 4'b0001; bus.burst_len = (b == 0) ? 3'd0 : 3'd7;
      repeat (5) tick();
      bus.req = '0;
      repeat (2) tick();
      chk((b == 0) ? "bl0_pops" : "bl7_pops", pop_log.size(), MAX_BURST);
      fifo.delete();
    end

    // Reset in the cycle of the second pop.
    clear_logs();
    for (int i = 0; i < 8; i++) fifo.push_back(DATA_W'($urandom));
    bus.req = 4'b0010; bus.burst_len = 4;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rmb_rd_en", s_rd_en, 0);
    chk("rmb_inflight", s_ovld, 1);
    rst = 1'b0;
    bus.req = 4'b0011;
    tick();
    chk("rmb_gnt", s_gnt, 0);
    chk("rmb_busy", s_busy, 0);
    chk("rmb_out_valid", s_ovld, 0);
    tick();
    chk("rmb_first", s_gnt, 4'b0001);
    bus.req = '0;
    repeat (2) tick();
    chk("rmb_pops", pop_log.size(), 2);
    if (pop_log.size() == 2) chk("rmb_winner", pop_log[1], 0);
    fifo.delete();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) bus.req = NUM_REQ'($urandom_range(0, 15));
      bus.burst_len = BL_W'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0 && fifo.size() < 16) fifo.push_back(DATA_W'($urandom));
      force_empty = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; force_empty = 0; bus.req = '0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
